// File: rtl/usb_tx_arb_pkg.sv
// Shared definitions for the USB transmit arbiter: FSM states, header
// layout and the channel id width.
package usb_tx_arb_pkg;

   localparam int CH_W          = 2;
   localparam int SEQ_W         = 8;
   localparam int HDR_W         = 16;
   localparam logic [3:0] HDR_MAGIC = 4'hA;
   localparam int HDR_MAGIC_LSB = 12;
   localparam int HDR_CONT_BIT  = 11;
   localparam int HDR_RSVD_BIT  = 10;
   localparam int HDR_OWNER_LSB = 8;
   localparam int HDR_SEQ_LSB   = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEADER  = 2'd1,
      PAYLOAD = 2'd2
   } arb_state_e;

   // Assemble a packet header word from its fields.
   function automatic logic [HDR_W-1:0] make_header(
      input logic             cont,
      input logic [CH_W-1:0]  ch,
      input logic [SEQ_W-1:0] seq
   );
      logic [HDR_W-1:0] h;
      h = {HDR_W{1'b0}};
      h[HDR_MAGIC_LSB +: 4]    = HDR_MAGIC;
      h[HDR_CONT_BIT]          = cont;
      h[HDR_RSVD_BIT]          = 1'b0;
      h[HDR_OWNER_LSB +: CH_W] = ch;
      h[HDR_SEQ_LSB +: SEQ_W]  = seq;
      return h;
   endfunction

endpackage

// File: rtl/usb_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first requesting channel after 'last'.
module rr_pick
   import usb_tx_arb_pkg::*;
#(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] last,
   output logic [CH_W-1:0] idx,
   output logic            any
);

   logic [3:0]      req_w;
   logic [CH_W-1:0] cand;
   logic            hit;

   assign req_w = 4'(req);

   // Scan last+1, last+2, ... wrapping at NCH; the first hit wins.
   always_comb begin
      idx  = 2'd0;
      any  = 1'b0;
      cand = 2'd0;
      hit  = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
         cand = CH_W'((int'(last) + k) % NCH);
         hit  = req_w[cand] & ~any;
         any  = any | hit;
         idx  = hit ? cand : idx;
      end
   end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Multiplexes NCH packet sources onto one 245-FIFO bridge write port.
// Each grant is prefixed by a header word; long packets are split into
// bursts of at most MAX_BURST words, continuations flagged in the header.
module usb_tx_arbiter
   import usb_tx_arb_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int DW        = 16,
   parameter int MAX_BURST = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NCH-1:0]    src_valid,
   input  logic [NCH*DW-1:0] src_data,
   input  logic [NCH-1:0]    src_last,
   output logic [NCH-1:0]    src_ready,
   output logic              wr_req,
   input  logic              wr_gnt,
   output logic [DW-1:0]     wr_data,
   output logic [1:0]        owner,
   output logic              busy
);

   localparam int BCW = $clog2(MAX_BURST);

   arb_state_e                 state;
   logic [CH_W-1:0]            last_owner;
   logic [NCH-1:0][SEQ_W-1:0]  seq;
   logic [NCH-1:0]             trunc;
   logic [BCW-1:0]             burst_cnt;

   logic [CH_W-1:0]            pick_idx;
   logic                       pick_any;
   logic                       own_valid;
   logic                       own_last;
   logic [DW-1:0]              own_data;
   logic                       xfer;
   logic                       cap;
   logic [HDR_W-1:0]           hdr;

   logic                       wr_req_s;
   logic [DW-1:0]              wr_data_s;
   logic [NCH-1:0]             src_ready_s;

   rr_pick #(.NCH(NCH)) u_rr_pick (
      .req  (src_valid),
      .last (last_owner),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   assign own_valid = src_valid[owner];
   assign own_last  = src_last[owner];
   assign own_data  = src_data[owner*DW +: DW];
   assign xfer      = (state == PAYLOAD) && wr_gnt && own_valid;
   assign cap       = (burst_cnt == BCW'(MAX_BURST-1));
   assign hdr       = make_header(trunc[owner], owner, seq[owner]);

   // Bridge-side and source-side handshake for the current state.
   always_comb begin
      wr_req_s    = 1'b0;
      wr_data_s   = {DW{1'b0}};
      src_ready_s = {NCH{1'b0}};
      case (state)
         IDLE: begin
            wr_req_s  = 1'b0;
            wr_data_s = {DW{1'b0}};
         end
         HEADER: begin
            wr_req_s  = 1'b1;
            wr_data_s = DW'(hdr);
         end
         PAYLOAD: begin
            wr_req_s           = own_valid;
            wr_data_s          = own_data;
            src_ready_s[owner] = wr_gnt & own_valid;
         end
         default: begin
            wr_req_s  = 1'b0;
            wr_data_s = {DW{1'b0}};
         end
      endcase
   end

   // Outputs are forced quiet for as long as reset is held.
   assign wr_req    = wr_req_s & rst_n;
   assign wr_data   = wr_data_s & {DW{rst_n}};
   assign src_ready = src_ready_s & {NCH{rst_n}};
   assign busy      = (state != IDLE) & rst_n;

   // Arbitration FSM with per-channel sequence and truncation bookkeeping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= CH_W'(NCH-1);
         seq        <= '0;
         trunc      <= {NCH{1'b0}};
         burst_cnt  <= {BCW{1'b0}};
         owner      <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  owner <= pick_idx;
                  state <= HEADER;
               end
            end
            HEADER: begin
               if (wr_gnt) begin
                  seq[owner] <= seq[owner] + 8'd1;
                  burst_cnt  <= {BCW{1'b0}};
                  state      <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  burst_cnt <= burst_cnt + BCW'(1);
                  if (own_last) begin
                     trunc[owner] <= 1'b0;
                     last_owner   <= owner;
                     state        <= IDLE;
                  end else if (cap) begin
                     trunc[owner] <= 1'b1;
                     last_owner   <= owner;
                     state        <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: directed scenarios plus randomized traffic,
// checked against a packet-level model of the bridge word stream.
module tb_usb_tx_arbiter;

   localparam int MAXB = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  src_valid;
   logic [63:0] src_data;
   logic [3:0]  src_last;
   logic [3:0]  src_ready;
   logic        wr_req;
   logic        wr_gnt;
   logic [15:0] wr_data;
   logic [1:0]  owner;
   logic        busy;

   usb_tx_arbiter #(.NCH(4), .DW(16), .MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_last  (src_last),
      .src_ready (src_ready),
      .wr_req    (wr_req),
      .wr_gnt    (wr_gnt),
      .wr_data   (wr_data),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [16:0] src_q [4][$];   // {last, data} per source, head is on the bus
   logic [15:0] exp_q [$];      // words the bridge should accept, in order
   logic [15:0] got_q [$];      // words the bridge did accept in this run
   logic        busy_hist [$];
   logic        gnt_pat [$];
   int          gap_left = 0;
   int          ready_pulses = 0;

   logic [7:0]  m_seq [4];
   logic        m_trunc [4];
   int          m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_seq[i]   = 8'd0;
         m_trunc[i] = 1'b0;
      end
      m_last = 3;
   endtask

   task automatic add_word(input int ch, input logic [15:0] d, input logic last);
      src_q[ch].push_back({last, d});
   endtask

   // Expected stream: serve non-empty sources round robin from m_last+1,
   // header then up to MAXB words of the head packet per grant.
   task automatic plan();
      logic [16:0] mq [4][$];
      logic [16:0] w;
      int c, n, cc;
      bit found;
      for (int i = 0; i < 4; i++) mq[i] = src_q[i];
      while (1) begin
         found = 1'b0;
         c = 0;
         for (int k = 1; k <= 4; k++) begin
            cc = (m_last + k) % 4;
            if (!found && mq[cc].size() > 0) begin
               found = 1'b1;
               c = cc;
            end
         end
         if (!found) break;
         exp_q.push_back({4'hA, m_trunc[c], 1'b0, 2'(c), m_seq[c]});
         m_seq[c] = m_seq[c] + 8'd1;
         n = 0;
         while (mq[c].size() > 0) begin
            w = mq[c].pop_front();
            exp_q.push_back(w[15:0]);
            n++;
            if (w[16]) begin
               m_trunc[c] = 1'b0;
               break;
            end
            if (n == MAXB) begin
               m_trunc[c] = 1'b1;
               break;
            end
         end
         m_last = c;
      end
   endtask

   task automatic drive(input int gnt_pct);
      logic [16:0] h;
      for (int c = 0; c < 4; c++) begin
         if (src_q[c].size() > 0 && gap_left == 0) begin
            h = src_q[c][0];
            src_valid[c]          = 1'b1;
            src_data[c*16 +: 16]  = h[15:0];
            src_last[c]           = h[16];
         end else begin
            src_valid[c]          = 1'b0;
            src_data[c*16 +: 16]  = 16'h0000;
            src_last[c]           = 1'b0;
         end
      end
      if (gnt_pat.size() > 0) wr_gnt = gnt_pat.pop_front();
      else wr_gnt = (int'($urandom_range(0, 99)) < gnt_pct) ? 1'b1 : 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0);
      @(negedge clk);
      check("rst_wr_req", wr_req, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_src_ready", src_ready, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_owner", owner, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic run_stream(input int gnt_pct, input int gap_at, input int rst_at, input int budget);
      int cyc = 0;
      int pops = 0;
      int rc;
      bit gap_done = 1'b0;
      bit rst_done = 1'b0;
      logic [16:0] head;
      logic [15:0] e;
      busy_hist.delete();
      got_q.delete();
      gap_left = 0;
      ready_pulses = 0;
      while (exp_q.size() > 0 && cyc < budget) begin
         drive(gnt_pct);
         @(negedge clk);
         if (src_ready != 4'b0000) begin
            check("rdy_onehot", $countones(src_ready), 1);
            check("rdy_gnt", {31'b0, wr_gnt & wr_req}, 1);
            rc = 0;
            for (int c = 0; c < 4; c++) if (src_ready[c]) rc = c;
            check("rdy_valid", src_valid[rc], 1);
            if (src_q[rc].size() > 0) begin
               head = src_q[rc].pop_front();
               check("rdy_data", wr_data, head[15:0]);
            end
            pops++;
            ready_pulses++;
         end
         if (wr_req && wr_gnt) begin
            e = exp_q.pop_front();
            check("stream", wr_data, e);
            got_q.push_back(wr_data);
         end
         busy_hist.push_back(busy);
         if (gap_left > 0) begin
            check("gap_no_req", wr_req, 0);
            check("gap_busy", busy, 1);
         end
         @(posedge clk); #1;
         cyc++;
         if (gap_left > 0) gap_left--;
         if (gap_at >= 0 && pops == gap_at && !gap_done) begin
            gap_done = 1'b1;
            gap_left = 3;
         end
         if (rst_at >= 0 && pops == rst_at && !rst_done) begin
            rst_done = 1'b1;
            rst_n = 1'b0;
            drive(gnt_pct);
            @(negedge clk);
            check("midrst_wr_req", wr_req, 0);
            check("midrst_ready", src_ready, 0);
            check("midrst_busy", busy, 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            model_reset();
            exp_q.delete();
            got_q.delete();
            plan();
            drive(gnt_pct);
            @(negedge clk);
            check("post_rst_req", wr_req, 0);
            check("post_rst_busy", busy, 0);
            @(posedge clk); #1;
         end
      end
      check("stream_done", exp_q.size(), 0);
   endtask

   function automatic int busy_ones();
      int n = 0;
      foreach (busy_hist[i]) if (busy_hist[i]) n++;
      return n;
   endfunction

   function automatic int busy_gaps();
      int first = -1;
      int last = -1;
      int n = 0;
      foreach (busy_hist[i]) begin
         if (busy_hist[i]) begin
            if (first < 0) first = i;
            last = i;
         end
      end
      for (int i = first + 1; i < last; i++) if (!busy_hist[i]) n++;
      return n;
   endfunction

   initial begin
      logic [15:0] w;
      int ord [5] = '{0, 1, 2, 3, 0};
      int ch, len;
      rst_n = 1'b0;
      src_valid = 4'h0;
      src_data = 64'h0;
      src_last = 4'h0;
      wr_gnt = 1'b0;

      // Reset state and a 3-word packet on channel 0.
      do_reset();
      add_word(0, 16'h1111, 1'b0);
      add_word(0, 16'h2222, 1'b0);
      add_word(0, 16'h3333, 1'b1);
      plan();
      run_stream(100, -1, -1, 50);
      check("t37_count", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("t37_hdr", got_q[0], 16'hA000);
         check("t37_w1", got_q[1], 16'h1111);
         check("t37_w3", got_q[3], 16'h3333);
      end
      check("t37_busy", busy_ones(), 4);

      // Follow-up packet on channel 0 carries seq 1.
      add_word(0, 16'h4444, 1'b1);
      plan();
      run_stream(100, -1, -1, 50);
      w = (got_q.size() > 0) ? got_q[0] : 16'h0000;
      check("t37_seq1", w, 16'hA001);

      // All channels ready: channel order 0,1,2,3,0, one idle between packets.
      do_reset();
      for (int c = 0; c < 4; c++) add_word(c, 16'h0100 + 16'(c), 1'b1);
      add_word(0, 16'h0500, 1'b1);
      plan();
      run_stream(100, -1, -1, 100);
      check("t38_count", got_q.size(), 10);
      if (got_q.size() == 10) begin
         for (int i = 0; i < 5; i++) begin
            w = got_q[2*i];
            check("t38_owner", w[9:8], ord[i]);
         end
      end
      check("t38_idle", busy_gaps(), 4);

      // Truncation at MAX_BURST=4: 6 words on channel 2.
      do_reset();
      for (int i = 0; i < 6; i++) add_word(2, 16'h2000 + 16'(i), i == 5);
      plan();
      run_stream(100, -1, -1, 100);
      check("t39_count", got_q.size(), 8);
      if (got_q.size() == 8) begin
         check("t39_hdr1", got_q[0], 16'hA200);
         check("t39_hdr2", got_q[5], 16'hAA01);
      end

      // Grant toggling during payload; grant in IDLE is ignored.
      for (int i = 0; i < 4; i++) add_word(1, 16'h5A00 + 16'(i), i == 3);
      gnt_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      plan();
      run_stream(100, -1, -1, 100);
      check("t40_pulses", ready_pulses, 4);
      check("t40_count", got_q.size(), 5);

      // Valid drop mid-packet holds the grant; channel 3 waits.
      do_reset();
      add_word(0, 16'h0A0A, 1'b0);
      add_word(0, 16'h0B0B, 1'b0);
      add_word(0, 16'h0C0C, 1'b1);
      add_word(3, 16'h3D3D, 1'b1);
      plan();
      run_stream(100, 1, -1, 100);
      check("t29_count", got_q.size(), 6);

      // Sequence number wraps after 256 packets on channel 1.
      do_reset();
      for (int i = 0; i < 257; i++) add_word(1, 16'(i), 1'b1);
      plan();
      run_stream(100, -1, -1, 2000);
      check("t41_count", got_q.size(), 514);
      if (got_q.size() == 514) begin
         w = got_q[510];
         check("t41_seq255", w[7:0], 8'd255);
         w = got_q[512];
         check("t41_seq0", w[7:0], 8'd0);
      end

      // Reset after the second payload word abandons the packet.
      do_reset();
      for (int i = 0; i < 4; i++) add_word(0, 16'h7700 + 16'(i), i == 3);
      plan();
      run_stream(100, -1, 2, 100);
      check("t42_count", got_q.size(), 3);
      w = (got_q.size() > 0) ? got_q[0] : 16'h0000;
      check("t42_hdr", w, 16'hA000);

      // Randomized traffic with random grant.
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < 12; p++) begin
            ch  = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) add_word(ch, 16'($urandom), i == len - 1);
         end
         plan();
         run_stream(70, -1, -1, 3000);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NCH, default 4, meaning the number of requesting sources (fixed 2..4; channel id is 2 bits).
REQ-002 The block SHALL have parameter DW, default 16, meaning the word width, equal to the user write width of the 245-FIFO bridge.
REQ-003 The block SHALL have parameter MAX_BURST, default 256, meaning the maximum payload words per grant (range 2..1024).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, which is also the bridge wr_clk.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port src_valid, input, NCH bits: per-source word available.
REQ-007 The block SHALL have port src_data, input, NCH*DW bits: per-source word, source i at bits [i*DW +: DW].
REQ-008 The block SHALL have port src_last, input, NCH bits: per-source last word of packet.
REQ-009 The block SHALL have port src_ready, output, NCH bits: per-source word consumed this cycle.
REQ-010 The block SHALL have port wr_req, output, 1 bit: word offered to the bridge.
REQ-011 The block SHALL have port wr_gnt, input, 1 bit: bridge accepted wr_data this cycle.
REQ-012 The block SHALL have port wr_data, output, DW bits: word to the bridge.
REQ-013 The block SHALL have port owner, output, 2 bits: currently granted channel, valid when busy=1.
REQ-014 The block SHALL have port busy, output, 1 bit: high in HEADER or PAYLOAD state.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, HEADER and PAYLOAD.
REQ-016 In IDLE with any src_valid high, the block SHALL pick the first valid channel scanning last_owner+1, +2, ... (mod NCH), register it as owner, and enter HEADER next cycle.
REQ-017 In IDLE with no src_valid high, the block SHALL remain in IDLE, with wr_req=0 and src_ready=0.
REQ-018 In HEADER, the block SHALL drive wr_req=1 and wr_data = {4'hA, cont, 1'b0, owner[1:0], seq[owner][7:0]}, zero-extended to DW, where cont=1 if the previous grant to this owner was truncated.
REQ-019 In HEADER, on wr_gnt=1 the block SHALL increment seq[owner] (8-bit, wraps 255->0), clear burst_cnt, and enter PAYLOAD.
REQ-020 In PAYLOAD, the block SHALL drive wr_req = src_valid[owner] and wr_data = source owner's word, combinationally.
REQ-021 In PAYLOAD, src_ready[owner] SHALL equal wr_gnt & src_valid[owner]; all other src_ready bits SHALL be 0.
REQ-022 A PAYLOAD transfer SHALL be defined as the cycle where wr_gnt=1 and src_valid[owner]=1; each transfer SHALL increment burst_cnt.
REQ-023 A transfer with src_last[owner]=1 SHALL clear trunc[owner], set last_owner=owner, and return the FSM to IDLE.
REQ-024 A transfer without src_last where burst_cnt reaches MAX_BURST-1 SHALL set trunc[owner], set last_owner=owner, and return to IDLE; the remainder of that packet is sent under a later header with cont=1.
REQ-025 When both src_last and the cap occur on the same transfer, src_last SHALL take precedence: trunc is cleared.
REQ-026 The block SHALL insert no idle cycle between HEADER acceptance and the first payload word.
REQ-027 The block SHALL insert exactly one IDLE cycle between packets.
REQ-028 wr_gnt while wr_req=0 SHALL be ignored.
REQ-029 src_valid deasserting mid-packet SHALL hold the grant, without timeout.
REQ-030 A source deasserting src_valid while in IDLE before being granted SHALL not be selected.
REQ-031 The block SHALL never assert wr_req for a non-owner source, and SHALL not reorder words within a source.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL set: state to IDLE, last_owner to NCH-1 (channel 0 served first), all seq to 0, all trunc to 0, burst_cnt to 0, and owner to 0.
REQ-033 During reset, the outputs SHALL be: wr_req=0, wr_data=0, src_ready=0, busy=0.
REQ-034 A reset mid-packet SHALL abandon the packet without a further wr_req; the next packet SHALL start with a fresh header carrying seq=0 and cont=0.

Structure
REQ-035 A package usb_tx_arb_pkg SHALL hold: the state enum, the header magic 4'hA, the header field positions, and the channel id width of 2.
REQ-036 A sub-module rr_pick SHALL implement the combinational round-robin selection, taking the request vector and last_owner and returning the granted index and an any-request flag.

Verification
REQ-037 Reset then ch0 sends a 3-word packet 0x1111, 0x2222, 0x3333 (last) with wr_gnt held at 1 -> the bridge sees 0xA000, 0x1111, 0x2222, 0x3333; busy is high 4 cycles; seq[0] becomes 1.
REQ-038 All 4 channels hold a 1-word packet continuously -> headers are issued in channel order 0,1,2,3,0 with owner field matching, one IDLE cycle between packets.
REQ-039 With MAX_BURST=4, ch2 streams 6 words -> the bridge sees 0xA200, 4 words, then 0xAA01, 2 words; cont=1 on the second header only.
REQ-040 wr_gnt is toggled 1,0,0,1 during PAYLOAD -> src_ready pulses only on granted cycles; no word is duplicated or dropped.
REQ-041 ch1 sends 256 single-word packets -> the header seq field runs 0..255 and the next header shows seq=0.
REQ-042 rst_n is pulled low for 1 cycle after the second payload word -> wr_req is 0 the next cycle; the next ch0 packet header is 0xA000.
